// File: rtl/elevator_fsm.sv
// Single-cab elevator controller: latches floor calls and serves them in SCAN order.
// Move and door timing are parameterised; every output comes straight from a flop.
module elevator_fsm #(
    parameter int unsigned N_FLOORS    = 4,
    parameter int unsigned MOVE_CYCLES = 4,
    parameter int unsigned DOOR_CYCLES = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [N_FLOORS-1:0]         req,
    output logic [$clog2(N_FLOORS)-1:0] floor,
    output logic                        motor_up,
    output logic                        motor_down,
    output logic                        door_open,
    output logic [N_FLOORS-1:0]         pending
);

    localparam int unsigned FLOOR_W = $clog2(N_FLOORS);
    localparam int unsigned MOVE_W  = $clog2(MOVE_CYCLES + 1);
    localparam int unsigned DOOR_W  = $clog2(DOOR_CYCLES + 1);
    localparam logic [MOVE_W-1:0] MOVE_LAST = MOVE_W'(MOVE_CYCLES - 1);
    localparam logic [DOOR_W-1:0] DOOR_LAST = DOOR_W'(DOOR_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_MOVE_UP   = 2'd1,
        S_MOVE_DOWN = 2'd2,
        S_DOOR      = 2'd3
    } state_t;

    state_t               r_state;
    logic [FLOOR_W-1:0]   r_floor;
    logic                 r_dir;
    logic [N_FLOORS-1:0]  r_pending;
    logic [MOVE_W-1:0]    r_move_cnt;
    logic [DOOR_W-1:0]    r_door_cnt;
    logic                 r_motor_up;
    logic                 r_motor_down;
    logic                 r_door_open;

    state_t               w_state_nxt;
    logic [FLOOR_W-1:0]   w_floor_nxt;
    logic                 w_dir_nxt;
    logic [N_FLOORS-1:0]  w_pending_nxt;
    logic [MOVE_W-1:0]    w_move_cnt_nxt;
    logic [DOOR_W-1:0]    w_door_cnt_nxt;
    logic [FLOOR_W-1:0]   w_arrive_floor;
    logic [N_FLOORS-1:0]  w_above;
    logic [N_FLOORS-1:0]  w_below;
    logic [N_FLOORS-1:0]  w_cur_oh;
    logic [N_FLOORS-1:0]  w_arrive_oh;
    logic [N_FLOORS-1:0]  w_nxt_oh;
    logic [N_FLOORS-1:0]  w_req_eff;
    logic                 w_call_above;
    logic                 w_call_below;
    logic                 w_call_here;
    logic                 w_arrive_hit;

    // Floor the cab reaches at the end of the current one-floor move.
    assign w_arrive_floor = (r_state == S_MOVE_DOWN) ? (r_floor - FLOOR_W'(1))
                                                     : (r_floor + FLOOR_W'(1));

    always_comb begin
        w_above     = '0;
        w_below     = '0;
        w_cur_oh    = '0;
        w_arrive_oh = '0;
        for (int i = 0; i < int'(N_FLOORS); i++) begin
            w_above[i]     = (FLOOR_W'(i) > r_floor);
            w_below[i]     = (FLOOR_W'(i) < r_floor);
            w_cur_oh[i]    = (FLOOR_W'(i) == r_floor);
            w_arrive_oh[i] = (FLOOR_W'(i) == w_arrive_floor);
        end
    end

    assign w_call_above = |(r_pending & w_above);
    assign w_call_below = |(r_pending & w_below);
    assign w_call_here  = |(r_pending & w_cur_oh);
    // A call pressed on the very arrival edge still stops the cab there.
    assign w_arrive_hit = |((r_pending | req) & w_arrive_oh);

    always_comb begin
        w_state_nxt    = r_state;
        w_floor_nxt    = r_floor;
        w_dir_nxt      = r_dir;
        w_move_cnt_nxt = r_move_cnt;
        w_door_cnt_nxt = r_door_cnt;
        case (r_state)
            S_IDLE: begin
                if (w_call_here) begin
                    w_state_nxt    = S_DOOR;
                    w_door_cnt_nxt = '0;
                end else if (w_call_above && (!w_call_below || r_dir)) begin
                    w_state_nxt    = S_MOVE_UP;
                    w_dir_nxt      = 1'b1;
                    w_move_cnt_nxt = '0;
                end else if (w_call_below) begin
                    w_state_nxt    = S_MOVE_DOWN;
                    w_dir_nxt      = 1'b0;
                    w_move_cnt_nxt = '0;
                end
            end
            S_MOVE_UP, S_MOVE_DOWN: begin
                if (r_move_cnt == MOVE_LAST) begin
                    w_move_cnt_nxt = '0;
                    w_floor_nxt    = w_arrive_floor;
                    if (w_arrive_hit) begin
                        w_state_nxt    = S_DOOR;
                        w_door_cnt_nxt = '0;
                    end
                end else begin
                    w_move_cnt_nxt = r_move_cnt + MOVE_W'(1);
                end
            end
            S_DOOR: begin
                if (r_door_cnt == DOOR_LAST) begin
                    w_state_nxt    = S_IDLE;
                    w_door_cnt_nxt = '0;
                end else begin
                    w_door_cnt_nxt = r_door_cnt + DOOR_W'(1);
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Call latching: presses at the open-door floor are ignored, and the
    // floor being entered with the door opening is cleared (clear wins).
    always_comb begin
        w_nxt_oh  = '0;
        w_req_eff = req;
        for (int i = 0; i < int'(N_FLOORS); i++) begin
            w_nxt_oh[i] = (FLOOR_W'(i) == w_floor_nxt);
        end
        if (r_state == S_DOOR) begin
            w_req_eff = req & ~w_cur_oh;
        end
        w_pending_nxt = r_pending | w_req_eff;
        if ((w_state_nxt == S_DOOR) && (r_state != S_DOOR)) begin
            w_pending_nxt = w_pending_nxt & ~w_nxt_oh;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_floor      <= '0;
            r_dir        <= 1'b1;
            r_pending    <= '0;
            r_move_cnt   <= '0;
            r_door_cnt   <= '0;
            r_motor_up   <= 1'b0;
            r_motor_down <= 1'b0;
            r_door_open  <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_floor      <= w_floor_nxt;
            r_dir        <= w_dir_nxt;
            r_pending    <= w_pending_nxt;
            r_move_cnt   <= w_move_cnt_nxt;
            r_door_cnt   <= w_door_cnt_nxt;
            r_motor_up   <= (w_state_nxt == S_MOVE_UP);
            r_motor_down <= (w_state_nxt == S_MOVE_DOWN);
            r_door_open  <= (w_state_nxt == S_DOOR);
        end
    end

    assign floor      = r_floor;
    assign pending    = r_pending;
    assign motor_up   = r_motor_up;
    assign motor_down = r_motor_down;
    assign door_open  = r_door_open;

endmodule

// File: tb/tb_elevator_fsm.sv
// Directed bench for elevator_fsm: single call, long travel, SCAN order,
// door/arrival corner cases, async reset, and a random safety soak.
module tb_elevator_fsm;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] req = 4'b0000;
    logic [1:0] floor;
    logic       motor_up;
    logic       motor_down;
    logic       door_open;
    logic [3:0] pending;

    int n_vec  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    elevator_fsm #(
        .N_FLOORS   (4),
        .MOVE_CYCLES(4),
        .DOOR_CYCLES(8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .floor     (floor),
        .motor_up  (motor_up),
        .motor_down(motor_down),
        .door_open (door_open),
        .pending   (pending)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic outs(input string tag, input logic [1:0] f, input logic u,
                        input logic d, input logic o, input logic [3:0] p);
        check({tag, ".floor"},   32'(floor),      32'(f));
        check({tag, ".up"},      32'(motor_up),   32'(u));
        check({tag, ".down"},    32'(motor_down), 32'(d));
        check({tag, ".door"},    32'(door_open),  32'(o));
        check({tag, ".pending"}, 32'(pending),    32'(p));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = 4'b0000;
        steps(2);
        rst = 1'b0;
    endtask

    function automatic logic has_dir(input logic [3:0] p, input logic [1:0] f, input logic up);
        logic r;
        r = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (up && (i > int'(f)) && p[i]) r = 1'b1;
            if (!up && (i < int'(f)) && p[i]) r = 1'b1;
        end
        return r;
    endfunction

    initial begin
        logic [1:0] prev_floor;
        logic [3:0] prev_pending;
        logic       prev_up;
        logic       prev_down;
        int         dfl;

        // Single call to floor 1
        do_reset();
        outs("reset", 2'd0, 1'b0, 1'b0, 1'b0, 4'b0000);
        req = 4'b0010;
        step();
        req = 4'b0000;
        outs("t1_latch", 2'd0, 1'b0, 1'b0, 1'b0, 4'b0010);
        for (int k = 0; k < 4; k++) begin
            step();
            outs("t1_move", 2'd0, 1'b1, 1'b0, 1'b0, 4'b0010);
        end
        step();
        outs("t1_arrive", 2'd1, 1'b0, 1'b0, 1'b1, 4'b0000);
        for (int k = 0; k < 7; k++) begin
            step();
            outs("t1_door", 2'd1, 1'b0, 1'b0, 1'b1, 4'b0000);
        end
        step();
        outs("t1_idle", 2'd1, 1'b0, 1'b0, 1'b0, 4'b0000);
        step();
        outs("t1_idle2", 2'd1, 1'b0, 1'b0, 1'b0, 4'b0000);

        // Long travel 0 -> 3 without intermediate stops
        do_reset();
        req = 4'b1000;
        step();
        req = 4'b0000;
        outs("t2_latch", 2'd0, 1'b0, 1'b0, 1'b0, 4'b1000);
        for (int k = 0; k < 12; k++) begin
            step();
            outs("t2_move", 2'(k / 4), 1'b1, 1'b0, 1'b0, 4'b1000);
        end
        step();
        outs("t2_arrive", 2'd3, 1'b0, 1'b0, 1'b1, 4'b0000);
        steps(7);
        outs("t2_door_end", 2'd3, 1'b0, 1'b0, 1'b1, 4'b0000);
        step();
        outs("t2_idle", 2'd3, 1'b0, 1'b0, 0, 4'b0000);

        // SCAN: park at floor 2 with dir=up, then call 3 and 1 together
        do_reset();
        req = 4'b0100;
        step();
        req = 4'b0000;
        steps(8);
        outs("t3_pass1", 2'd1, 1'b1, 1'b0, 1'b0, 4'b0100);
        step();
        outs("t3_at2", 2'd2, 1'b0, 1'b0, 1'b1, 4'b0000);
        steps(8);
        outs("t3_idle2", 2'd2, 1'b0, 1'b0, 1'b0, 4'b0000);
        req = 4'b1010;
        step();
        req = 4'b0000;
        outs("t3_latch", 2'd2, 1'b0, 1'b0, 1'b0, 4'b1010);
        step();
        outs("t3_go_up", 2'd2, 1'b1, 1'b0, 1'b0, 4'b1010);
        steps(4);
        outs("t3_at3", 2'd3, 1'b0, 1'b0, 1'b1, 4'b0010);
        steps(8);
        outs("t3_idle3", 2'd3, 1'b0, 1'b0, 1'b0, 4'b0010);
        step();
        outs("t3_go_down", 2'd3, 1'b0, 1'b1, 1'b0, 4'b0010);
        steps(4);
        outs("t3_pass2", 2'd2, 1'b0, 1'b1, 1'b0, 4'b0010);
        steps(4);
        outs("t3_at1", 2'd1, 1'b0, 1'b0, 1'b1, 4'b0000);

        // Press own floor while door is open: ignored, no reopen
        step();
        req = 4'b0010;
        step();
        req = 4'b0000;
        outs("t4_door_req", 2'd1, 1'b0, 1'b0, 1'b1, 4'b0000);
        steps(5);
        outs("t4_door_last", 2'd1, 1'b0, 1'b0, 1'b1, 4'b0000);
        step();
        outs("t4_closed", 2'd1, 1'b0, 1'b0, 1'b0, 4'b0000);
        steps(3);
        outs("t4_no_reopen", 2'd1, 1'b0, 1'b0, 1'b0, 4'b0000);

        // Call held through the arrival edge at floor 1: cleared, single opening
        do_reset();
        req = 4'b0010;
        step();
        outs("t5_latch", 2'd0, 1'b0, 1'b0, 1'b0, 4'b0010);
        steps(4);
        outs("t5_move", 2'd0, 1'b1, 1'b0, 1'b0, 4'b0010);
        step();
        outs("t5_arrive", 2'd1, 1'b0, 1'b0, 1'b1, 4'b0000);
        req = 4'b0000;
        steps(7);
        outs("t5_door", 2'd1, 1'b0, 1'b0, 1'b1, 4'b0000);
        step();
        outs("t5_closed", 2'd1, 1'b0, 1'b0, 1'b0, 4'b0000);
        steps(3);
        outs("t5_once", 2'd1, 1'b0, 1'b0, 1'b0, 4'b0000);

        // Async reset in the middle of a move at floor 1
        do_reset();
        req = 4'b1000;
        step();
        req = 4'b0000;
        steps(6);
        outs("t6_mid", 2'd1, 1'b1, 1'b0, 1'b0, 4'b1000);
        #2;
        rst = 1'b1;
        #1;
        outs("t6_async", 2'd0, 1'b0, 1'b0, 1'b0, 4'b0000);
        steps(2);
        rst = 1'b0;
        steps(4);
        outs("t6_after", 2'd0, 1'b0, 1'b0, 1'b0, 4'b0000);

        // Random soak: motor/door exclusion and legal movement
        do_reset();
        prev_floor   = floor;
        prev_pending = pending;
        prev_up      = motor_up;
        prev_down    = motor_down;
        for (int c = 0; c < 10000; c++) begin
            req = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000;
            step();
            check("mx_up_down", 32'(motor_up & motor_down), 32'd0);
            check("mx_motor_door", 32'((motor_up | motor_down) & door_open), 32'd0);
            check("up_at_top", 32'(motor_up && (floor == 2'd3)), 32'd0);
            check("down_at_bottom", 32'(motor_down && (floor == 2'd0)), 32'd0);
            dfl = int'(floor) - int'(prev_floor);
            check("floor_step", 32'((dfl >= -1) && (dfl <= 1)), 32'd1);
            if (motor_up && !prev_up)
                check("up_entry_call", 32'(has_dir(prev_pending, prev_floor, 1'b1)), 32'd1);
            if (motor_down && !prev_down)
                check("down_entry_call", 32'(has_dir(prev_pending, prev_floor, 1'b0)), 32'd1);
            prev_floor   = floor;
            prev_pending = pending;
            prev_up      = motor_up;
            prev_down    = motor_down;
        end
        req = 4'b0000;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
